win_banner_ctrl: RTL and testbench

WIN_BANNER_CTRL -- requirements
Module: win_banner_ctrl

---
 rtl/win_banner_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_win_banner_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/win_banner_ctrl.sv
// win_banner_ctrl
// Slides a "you win" banner down from the top of the screen, blinks it, and
// then holds it on screen. It also fetches the banner sprite words from a ROM
// two pixels ahead of the beam.
//
// Ports:
//   Clk, Reset_n     - system clock (rising edge), async active-low reset
//   pixel_tick       - one-cycle strobe per pixel (ticks >= 4 Clk apart)
//   frame_start      - one-cycle strobe per frame
//   game_won         - level request to show the banner
//   DrawX, DrawY     - current beam pixel, sampled on pixel_tick
//   rom_data         - sprite ROM word, valid 2 Clk after rom_en is sampled
//   rom_addr, rom_en - sprite ROM word address / read strobe
//   win_data         - sprite word for the pixel currently on screen
//   winX, winY       - banner origin
//   banner_visible   - downstream palette output should be shown
//   busy             - controller is not idle
module win_banner_ctrl #(
    parameter int WIN_W         = 266,
    parameter int WIN_H         = 64,
    parameter int WIN_X         = 187,
    parameter int Y_TARGET      = 208,
    parameter int SLIDE_STEP    = 4,
    parameter int BLINK_FRAMES  = 16,
    parameter int BLINK_TOGGLES = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pixel_tick,
    input  logic        frame_start,
    input  logic        game_won,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [31:0] rom_data,
    output logic [11:0] rom_addr,
    output logic        rom_en,
    output logic [31:0] win_data,
    output logic [9:0]  winX,
    output logic [9:0]  winY,
    output logic        banner_visible,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLIDE = 2'd1,
        BLINK = 2'd2,
        SHOW  = 2'd3
    } state_t;

    localparam int BF_W = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int BT_W = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
    localparam logic [BF_W-1:0] BF_LAST  = BF_W'(BLINK_FRAMES - 1);
    localparam logic [BT_W-1:0] BT_LAST  = BT_W'(BLINK_TOGGLES - 1);
    localparam logic [10:0]     Y_TGT_C  = 11'(Y_TARGET);
    localparam logic [10:0]     STEP_C   = 11'(SLIDE_STEP);
    localparam logic [10:0]     WIN_H_C  = 11'(WIN_H);
    localparam logic [10:0]     X_LO_C   = 11'(WIN_X);
    localparam logic [10:0]     X_HI_C   = 11'(WIN_X + WIN_W);
    localparam logic [10:0]     X_MAX_C  = 11'd639;
    localparam logic [14:0]     WIN_W_C  = 15'(WIN_W);

    state_t          state_r, state_nxt_s;
    logic [9:0]      winy_r, winy_nxt_s;
    logic [9:0]      winx_r;
    logic            vis_r, vis_nxt_s;
    logic [BF_W-1:0] bcnt_r, bcnt_nxt_s;
    logic [BT_W-1:0] tcnt_r, tcnt_nxt_s;
    logic            busy_r, banner_r;

    logic [10:0]     slide_sum_s;
    logic            slide_hit_s, blink_wrap_s, blink_done_s, kill_s;

    logic [10:0]     tx_s, dx_s, dy_s;
    logic            inside_s;
    logic [14:0]     prod_s, lin_s;
    logic            in_q2_nxt_s;

    logic            rom_en_r, req_p0_r, req_p1_r, req_p2_r, in_p1_r, in_p2_r;
    logic            in_q1_r, in_q2_r;
    logic [11:0]     rom_addr_r;
    logic [31:0]     stage_r, win_data_r;

    // Frame-level conditions shared by the FSM and its datapath.
    always_comb begin
        slide_sum_s  = {1'b0, winy_r} + STEP_C;
        slide_hit_s  = (slide_sum_s >= Y_TGT_C);
        blink_wrap_s = (bcnt_r == BF_LAST);
        blink_done_s = blink_wrap_s && (tcnt_r == BT_LAST);
        // Dropping game_won aborts any activity and flushes the fetch pipeline.
        kill_s       = (state_r == IDLE) || !game_won;
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if ((state_r != IDLE) && !game_won) begin
            state_nxt_s = IDLE;
        end else if (frame_start) begin
            case (state_r)
                IDLE:    state_nxt_s = game_won ? SLIDE : IDLE;
                SLIDE:   state_nxt_s = slide_hit_s ? BLINK : SLIDE;
                BLINK:   state_nxt_s = blink_done_s ? SHOW : BLINK;
                SHOW:    state_nxt_s = SHOW;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM outputs: next banner position, visibility and blink counters.
    always_comb begin
        winy_nxt_s = winy_r;
        vis_nxt_s  = vis_r;
        bcnt_nxt_s = bcnt_r;
        tcnt_nxt_s = tcnt_r;
        if ((state_r != IDLE) && !game_won) begin
            vis_nxt_s = 1'b0;           // winY intentionally held until re-entry
        end else if (frame_start) begin
            case (state_r)
                IDLE: begin
                    if (game_won) begin
                        winy_nxt_s = 10'd0;
                        vis_nxt_s  = 1'b1;
                        bcnt_nxt_s = '0;
                        tcnt_nxt_s = '0;
                    end else begin
                        winy_nxt_s = winy_r;
                    end
                end
                SLIDE: begin
                    winy_nxt_s = slide_hit_s ? 10'(Y_TARGET) : slide_sum_s[9:0];
                end
                BLINK: begin
                    if (blink_wrap_s) begin
                        bcnt_nxt_s = '0;
                        vis_nxt_s  = ~vis_r;
                        tcnt_nxt_s = tcnt_r + 1'b1;
                    end else begin
                        bcnt_nxt_s = bcnt_r + 1'b1;
                    end
                end
                SHOW:    winy_nxt_s = winy_r;
                default: winy_nxt_s = winy_r;
            endcase
        end else begin
            winy_nxt_s = winy_r;
        end
    end

    // Target pixel two ahead of the beam, inside test and word address.
    // The multiply by WIN_W is unrolled into shifted adds of the set bits.
    always_comb begin
        tx_s     = {1'b0, DrawX} + 11'd2;
        dx_s     = tx_s - X_LO_C;
        dy_s     = {1'b0, DrawY} - {1'b0, winy_r};
        inside_s = (tx_s <= X_MAX_C) && (tx_s >= X_LO_C) && (tx_s < X_HI_C) &&
                   ({1'b0, DrawY} >= {1'b0, winy_r}) &&
                   ({1'b0, DrawY} < ({1'b0, winy_r} + WIN_H_C));
        prod_s   = 15'd0;
        for (int i = 0; i < 15; i++) begin
            prod_s = prod_s + (WIN_W_C[i] ? ({4'd0, dy_s} << i) : 15'd0);
        end
        lin_s       = prod_s + {4'd0, dx_s};
        in_q2_nxt_s = kill_s ? 1'b0 : (pixel_tick ? in_q1_r : in_q2_r);
    end

    // Frame-rate registers and registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            winy_r   <= 10'd0;
            winx_r   <= 10'(WIN_X);
            vis_r    <= 1'b0;
            bcnt_r   <= '0;
            tcnt_r   <= '0;
            busy_r   <= 1'b0;
            banner_r <= 1'b0;
        end else begin
            winy_r   <= winy_nxt_s;
            winx_r   <= 10'(WIN_X);
            vis_r    <= vis_nxt_s;
            bcnt_r   <= bcnt_nxt_s;
            tcnt_r   <= tcnt_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
            banner_r <= vis_nxt_s & in_q2_nxt_s;
        end
    end

    // Sprite fetch pipeline: request, 2-cycle ROM latency, staging, display.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_en_r   <= 1'b0;
            rom_addr_r <= 12'd0;
            req_p0_r   <= 1'b0;
            req_p1_r   <= 1'b0;
            req_p2_r   <= 1'b0;
            in_p1_r    <= 1'b0;
            in_p2_r    <= 1'b0;
            in_q1_r    <= 1'b0;
            in_q2_r    <= 1'b0;
            stage_r    <= 32'd0;
            win_data_r <= 32'd0;
        end else if (kill_s) begin
            rom_en_r   <= 1'b0;
            req_p0_r   <= 1'b0;
            req_p1_r   <= 1'b0;
            req_p2_r   <= 1'b0;
            in_p1_r    <= 1'b0;
            in_p2_r    <= 1'b0;
            in_q1_r    <= 1'b0;
            in_q2_r    <= 1'b0;
            stage_r    <= 32'd0;
            win_data_r <= 32'd0;
        end else begin
            rom_en_r <= pixel_tick && inside_s;
            req_p0_r <= pixel_tick;
            if (pixel_tick && inside_s) begin
                rom_addr_r <= 12'(lin_s >> 3);
            end
            req_p1_r <= req_p0_r;
            in_p1_r  <= rom_en_r;
            req_p2_r <= req_p1_r;
            in_p2_r  <= in_p1_r;
            // Outside targets stage a zero word so the palette shows nothing.
            if (req_p2_r) begin
                stage_r <= in_p2_r ? rom_data : 32'd0;
            end
            if (pixel_tick) begin
                win_data_r <= stage_r;
                in_q1_r    <= inside_s;
                in_q2_r    <= in_q1_r;
            end
        end
    end

    assign rom_en         = rom_en_r;
    assign rom_addr       = rom_addr_r;
    assign win_data       = win_data_r;
    assign winX           = winx_r;
    assign winY           = winy_r;
    assign banner_visible = banner_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_win_banner_ctrl.sv
module tb_win_banner_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pixel_tick = 1'b0;
    logic        frame_start = 1'b0;
    logic        game_won = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [31:0] rom_data = 32'd0;
    logic [11:0] rom_addr;
    logic        rom_en;
    logic [31:0] win_data;
    logic [9:0]  winX, winY;
    logic        banner_visible, busy;

    int checks = 0;
    int errors = 0;

    win_banner_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_tick(pixel_tick),
        .frame_start(frame_start), .game_won(game_won),
        .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data),
        .rom_addr(rom_addr), .rom_en(rom_en), .win_data(win_data),
        .winX(winX), .winY(winY), .banner_visible(banner_visible), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom_fn(input logic [11:0] a);
        return 32'hA5A5A5A5 ^ {20'd0, a};
    endfunction

    // ROM model: two-register latency after rom_en is sampled
    logic        r1_v = 1'b0;
    logic [11:0] r1_a = 12'd0;
    always @(posedge Clk) begin
        r1_v <= rom_en;
        r1_a <= rom_addr;
        if (r1_v) rom_data <= rom_fn(r1_a);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic frame();
        @(negedge Clk) frame_start = 1'b1;
        @(negedge Clk) frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // one pixel tick; returns rom_en/rom_addr in the cycle after the tick and rom_en one cycle later
    task automatic tick(input logic [9:0] x, input logic [9:0] y,
                        output logic en, output logic [11:0] addr, output logic en_after);
        @(negedge Clk);
        DrawX = x; DrawY = y; pixel_tick = 1'b1;
        @(negedge Clk);
        pixel_tick = 1'b0;
        en = rom_en; addr = rom_addr;
        @(negedge Clk);
        en_after = rom_en;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        en;
        logic [11:0] addr;
    } vec_t;

    vec_t        vt [12];
    logic        en_s, en_after_s, prev_en;
    logic [11:0] addr_s, prev_addr;

    initial begin
        vt[0]  = '{10'd185,  10'd208, 1'b1, 12'd0};
        vt[1]  = '{10'd186,  10'd208, 1'b1, 12'd0};
        vt[2]  = '{10'd193,  10'd208, 1'b1, 12'd1};
        vt[3]  = '{10'd184,  10'd208, 1'b0, 12'd0};
        vt[4]  = '{10'd450,  10'd271, 1'b1, 12'd2127};
        vt[5]  = '{10'd451,  10'd271, 1'b0, 12'd0};
        vt[6]  = '{10'd200,  10'd240, 1'b1, 12'd1065};
        vt[7]  = '{10'd300,  10'd272, 1'b0, 12'd0};
        vt[8]  = '{10'd300,  10'd207, 1'b0, 12'd0};
        vt[9]  = '{10'd638,  10'd208, 1'b0, 12'd0};
        vt[10] = '{10'd1022, 10'd230, 1'b0, 12'd0};
        vt[11] = '{10'd185,  10'd208, 1'b1, 12'd0};

        // reset values
        #12;
        chk("rst_winX", winX, 32'd187);
        chk("rst_winY", winY, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_rom_en", rom_en, 32'd0);
        chk("rst_rom_addr", rom_addr, 32'd0);
        chk("rst_win_data", win_data, 32'd0);
        chk("rst_banner", banner_visible, 32'd0);
        @(negedge Clk) Reset_n = 1'b1;

        // idle: no fetch, no start without frame_start
        tick(10'd185, 10'd0, en_s, addr_s, en_after_s);
        chk("idle_rom_en", en_s, 32'd0);
        chk("idle_win_data", win_data, 32'd0);
        frame();
        chk("idle_no_won_busy", busy, 32'd0);
        game_won = 1'b1;
        repeat (3) @(negedge Clk);
        chk("won_no_frame_busy", busy, 32'd0);

        // slide
        frame();
        chk("slide_busy", busy, 32'd1);
        chk("slide_winY0", winY, 32'd0);
        frames(51);
        chk("slide_winY204", winY, 32'd204);
        frame();
        chk("slide_winY208", winY, 32'd208);

        // two inside ticks so banner_visible follows the visibility bit
        tick(10'd185, 10'd208, en_s, addr_s, en_after_s);
        tick(10'd185, 10'd208, en_s, addr_s, en_after_s);
        chk("blink_f0_vis", banner_visible, 32'd1);

        // blink
        frames(15);  chk("blink_f15_vis", banner_visible, 32'd1);
        frame();     chk("blink_f16_vis", banner_visible, 32'd0);
        frames(15);  chk("blink_f31_vis", banner_visible, 32'd0);
        frame();     chk("blink_f32_vis", banner_visible, 32'd1);
        frames(16);  chk("blink_f48_vis", banner_visible, 32'd0);
        frames(16);  chk("blink_f64_vis", banner_visible, 32'd1);
        chk("show_busy", busy, 32'd1);
        frames(16);  chk("show_hold_vis", banner_visible, 32'd1);
        chk("show_winY", winY, 32'd208);
        chk("show_winX", winX, 32'd187);

        // fetch vectors in SHOW; win_data of a request shows after the next tick
        prev_en = 1'b1; prev_addr = 12'd0;
        for (int i = 0; i < 12; i++) begin
            tick(vt[i].x, vt[i].y, en_s, addr_s, en_after_s);
            chk($sformatf("vec%0d_rom_en", i), en_s, vt[i].en);
            if (vt[i].en) chk($sformatf("vec%0d_rom_addr", i), addr_s, vt[i].addr);
            chk($sformatf("vec%0d_rom_en_pulse", i), en_after_s, 32'd0);
            chk($sformatf("vec%0d_win_data", i), win_data,
                prev_en ? rom_fn(prev_addr) : 32'd0);
            chk($sformatf("vec%0d_banner", i), banner_visible, prev_en);
            prev_en = vt[i].en; prev_addr = vt[i].addr;
        end

        // reset one clock after rom_en; stale response must be dropped
        @(negedge Clk);
        DrawX = 10'd193; DrawY = 10'd208; pixel_tick = 1'b1;
        @(negedge Clk) pixel_tick = 1'b0;
        chk("mid_fetch_rom_en", rom_en, 32'd1);
        chk("mid_fetch_rom_addr", rom_addr, 32'd1);
        @(negedge Clk) Reset_n = 1'b0;
        #1;
        chk("async_rst_rom_en", rom_en, 32'd0);
        chk("async_rst_rom_addr", rom_addr, 32'd0);
        chk("async_rst_win_data", win_data, 32'd0);
        chk("async_rst_banner", banner_visible, 32'd0);
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_winY", winY, 32'd0);
        chk("async_rst_winX", winX, 32'd187);
        @(negedge Clk) Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk($sformatf("stale_win_data_c%0d", i), win_data, 32'd0);
        end
        frame();
        chk("resume_busy", busy, 32'd1);
        chk("resume_winY", winY, 32'd0);
        tick(10'd185, 10'd0, en_s, addr_s, en_after_s);
        chk("resume_rom_en", en_s, 32'd1);
        chk("resume_win_data", win_data, 32'd0);

        // game_won dropped mid-slide
        tick(10'd185, 10'd0, en_s, addr_s, en_after_s);
        chk("slide2_win_data", win_data, rom_fn(12'd0));
        frames(5);
        chk("slide2_winY", winY, 32'd20);
        chk("slide2_vis", banner_visible, 32'd1);
        @(negedge Clk) game_won = 1'b0;
        @(negedge Clk);
        chk("drop_busy", busy, 32'd0);
        chk("drop_banner", banner_visible, 32'd0);
        chk("drop_winY_held", winY, 32'd20);
        chk("drop_win_data", win_data, 32'd0);
        frame();
        chk("drop_idle_winY", winY, 32'd20);
        chk("drop_idle_busy", busy, 32'd0);
        game_won = 1'b1;
        frame();
        chk("reentry_winY", winY, 32'd0);
        chk("reentry_busy", busy, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
